data_tag_decode: RTL and testbench

//  Receive-side counterpart of the sample tagger: consumes the strobed sample stream whose LSB carries the

---
 rtl/data_tag_decode.sv | 159 +++++++++++++++
 tb/tb_data_tag_decode.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_tag_decode.sv
// data_tag_decode
//   Receive-side counterpart of the sample tagger. Consumes a strobed sample
//   stream whose bit 0 marks the first sample of a window, strips the tag,
//   regenerates window framing and checks each window's length against a
//   programmed value.
//
//   Build option: DATA_TAG_DECODE_STICKY_EN
//     defined     -> err_short/err_long are sticky until err_clr at a posedge
//                    (a new error in the same cycle wins over err_clr)
//     not defined -> errors are one-cycle pulses with the offending data_valid;
//                    err_clr is ignored
//
//   Ports
//     clk          system clock
//     reset        synchronous, active-low reset
//     strobe       one-cycle sample valid
//     data_in      tagged sample, bit 0 = window-start tag
//     expected_len required samples per window (1..2^CNT_W-1)
//     err_clr      clears sticky errors (sticky build only)
//     data_out     accepted sample with bit 0 cleared
//     data_valid   qualifies data_out / sof
//     sof          first sample of a window
//     in_window    set by the first accepted tag, cleared only by reset
//     win_count    1-based index of the current sample in its window
//     last_len     length of the most recently closed window
//     len_valid    one-cycle pulse when last_len updates
//     err_short    closed window was shorter than expected_len
//     err_long     window grew past expected_len without a tag
//     win_total    number of windows started (wraps)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   SEEK  | waiting for the first tag; untagged samples are discarded
//   RUN   | framing windows; only reset returns to SEEK

module data_tag_decode #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  expected_len,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sof,
    output logic              in_window,
    output logic [CNT_W-1:0]  win_count,
    output logic [CNT_W-1:0]  last_len,
    output logic              len_valid,
    output logic              err_short,
    output logic              err_long,
    output logic [CNT_W-1:0]  win_total
);

    typedef enum logic {SEEK, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             long_seen_q, long_seen_d;
    logic [CNT_W-1:0] cnt_d;
    logic             accept, start, close;
    logic             new_short, new_long;
    logic             tag;

    assign tag = data_in[0];

    always_comb begin
        state_d     = state_q;
        long_seen_d = long_seen_q;
        cnt_d       = win_count;
        accept      = 1'b0;
        start       = 1'b0;
        close       = 1'b0;
        new_short   = 1'b0;
        new_long    = 1'b0;
        if (strobe) begin
            case (state_q)
                SEEK: begin
                    if (tag) begin
                        state_d     = RUN;
                        accept      = 1'b1;
                        start       = 1'b1;
                        cnt_d       = CNT_ONE;
                        long_seen_d = 1'b0;
                    end
                end
                RUN: begin
                    accept = 1'b1;
                    if (tag) begin
                        close       = 1'b1;
                        new_short   = (win_count < expected_len);
                        start       = 1'b1;
                        cnt_d       = CNT_ONE;
                        long_seen_d = 1'b0;
                    end else if (win_count != CNT_MAX) begin
                        cnt_d = win_count + CNT_ONE;
                        // New count equals expected_len+1; the flag keeps it
                        // to one report even if expected_len moves mid-window.
                        if (win_count == expected_len && !long_seen_q) begin
                            new_long    = 1'b1;
                            long_seen_d = 1'b1;
                        end
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SEEK;
            long_seen_q <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            sof         <= 1'b0;
            in_window   <= 1'b0;
            win_count   <= '0;
            last_len    <= '0;
            len_valid   <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            win_total   <= '0;
        end else begin
            state_q     <= state_d;
            long_seen_q <= long_seen_d;
            data_valid  <= accept;
            sof         <= start;
            len_valid   <= close;
            win_count   <= cnt_d;
            if (accept)
                data_out <= {data_in[DATA_W-1:1], 1'b0};
            if (start) begin
                in_window <= 1'b1;
                win_total <= win_total + CNT_ONE;
            end
            if (close)
                last_len <= win_count;
`ifdef DATA_TAG_DECODE_STICKY_EN
            err_short <= new_short | (err_short & ~err_clr);
            err_long  <= new_long  | (err_long  & ~err_clr);
`else
            err_short <= new_short;
            err_long  <= new_long;
`endif
        end
    end

`ifndef DATA_TAG_DECODE_STICKY_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_data_tag_decode.sv
module tb_data_tag_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        strobe = 1'b0;
    logic        err_clr = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic [15:0] expected_len = 16'd64;
    logic [15:0] data_out, win_count, last_len, win_total;
    logic        data_valid, sof, in_window, len_valid, err_short, err_long;

    data_tag_decode #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .data_in(data_in),
        .expected_len(expected_len), .err_clr(err_clr),
        .data_out(data_out), .data_valid(data_valid), .sof(sof),
        .in_window(in_window), .win_count(win_count), .last_len(last_len),
        .len_valid(len_valid), .err_short(err_short), .err_long(err_long),
        .win_total(win_total)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Window-level model: an unbounded sample count clamped to the counter
    // range, evaluated directly from the framing rules.
    bit          cmp_en = 0;
    bit          m_started = 0, m_long_fired = 0;
    int          m_cnt = 0;
    logic [15:0] m_dout = 0, m_last = 0, m_total = 0;
    bit          m_dv = 0, m_sof = 0, m_inw = 0, m_lv = 0, m_es = 0, m_el = 0;

    always @(posedge clk) begin
        bit ns, nl;
        int nv;
        ns = 0; nl = 0;
        m_dv = 0; m_sof = 0; m_lv = 0;
        if (!reset) begin
            m_started = 0; m_long_fired = 0; m_cnt = 0; m_dout = 0; m_last = 0;
            m_total = 0; m_inw = 0; m_es = 0; m_el = 0;
        end else begin
            if (strobe) begin
                if (data_in[0]) begin
                    if (m_started) begin
                        m_last = m_cnt[15:0];
                        m_lv = 1;
                        ns = (m_cnt < int'(expected_len));
                    end
                    m_started = 1; m_inw = 1; m_cnt = 1; m_long_fired = 0;
                    m_total = m_total + 16'd1;
                    m_sof = 1; m_dv = 1;
                    m_dout = {data_in[15:1], 1'b0};
                end else if (m_started) begin
                    nv = m_cnt + 1;
                    if (nv > 65535) nv = 65535;
                    if (nv != m_cnt && nv == int'(expected_len) + 1 && !m_long_fired) begin
                        nl = 1; m_long_fired = 1;
                    end
                    m_cnt = nv;
                    m_dv = 1;
                    m_dout = {data_in[15:1], 1'b0};
                end
            end
`ifdef DATA_TAG_DECODE_STICKY_EN
            m_es = ns | (m_es & !err_clr);
            m_el = nl | (m_el & !err_clr);
`else
            m_es = ns;
            m_el = nl;
`endif
        end
        cmp_en = 1;
    end

    // Event capture for the hand-computed expectations.
    int          n_dv = 0, n_sof = 0, n_lv = 0, n_err = 0, n_longrise = 0;
    logic [15:0] lv_last = 0, long_at = 0;
    logic        lv_short = 0, el_prev = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data_valid", data_valid, m_dv);
            chk("sof", sof, m_sof);
            chk("in_window", in_window, m_inw);
            chk("win_count", win_count, m_cnt[15:0]);
            chk("last_len", last_len, m_last);
            chk("len_valid", len_valid, m_lv);
            chk("err_short", err_short, m_es);
            chk("err_long", err_long, m_el);
            chk("win_total", win_total, m_total);
            if (m_dv) chk("data_out", data_out, m_dout);
            if (data_valid) n_dv++;
            if (data_valid && sof) n_sof++;
            if (len_valid) begin n_lv++; lv_last = last_len; lv_short = err_short; end
            if (err_short || err_long) n_err++;
            if (err_long && !el_prev) begin n_longrise++; long_at = win_count; end
            el_prev = err_long;
        end
    end

    task automatic send(input bit tag, input int gap);
        logic [15:0] r;
        r = 16'($urandom);
        @(negedge clk);
        strobe  = 1'b1;
        data_in = {r[15:1], tag};
        if (gap > 1) begin
            @(negedge clk);
            strobe = 1'b0;
            repeat (gap - 2) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        strobe = 1'b0;
        repeat (n - 1) @(negedge clk);
        #2;
    endtask

    task automatic clr_counts();
        n_dv = 0; n_sof = 0; n_lv = 0; n_err = 0; n_longrise = 0;
    endtask

    initial begin
        // 1: reset held with tagged strobes
        reset = 1'b0; strobe = 1'b1; data_in = 16'h0001; expected_len = 16'd64;
        repeat (3) @(negedge clk);
        #2;
        chk("t1_dv_count", n_dv, 0);
        chk("t1_win_total", win_total, 0);
        @(negedge clk);
        reset = 1'b1; strobe = 1'b0;

        // 2: four 64-sample windows, one strobe per 64 clocks
        idle(2);
        clr_counts();
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 64; s++)
                send(s == 0, 64);
        idle(2);
        chk("t2_sof_count", n_sof, 4);
        chk("t2_lv_count", n_lv, 3);
        chk("t2_last_len", last_len, 64);
        chk("t2_win_total", win_total, 4);
        chk("t2_err_cycles", n_err, 0);

        // 3: close window 4 (64), then a 60-sample window
        send(1'b1, 1);
        for (int s = 0; s < 59; s++) send(1'b0, 1);
        send(1'b1, 1);
        idle(2);
        chk("t3_last_len", lv_last, 60);
        chk("t3_err_short", lv_short, 1);

        // 4: 70 samples without a tag, then a tag
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        clr_counts();
        for (int s = 0; s < 69; s++) send(1'b0, 1);
        send(1'b1, 1);
        idle(2);
        chk("t4_long_rises", n_longrise, 1);
        chk("t4_long_at", long_at, 65);
        chk("t4_last_len", lv_last, 70);
        chk("t4_no_short", lv_short, 0);

        // 5: untagged samples before the first tag
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        idle(1);
        clr_counts();
        for (int s = 0; s < 5; s++) send(1'b0, 2);
        idle(1);
        chk("t5_dv_before_tag", n_dv, 0);
        @(negedge clk); strobe = 1'b1; data_in = 16'h1235;
        idle(2);
        chk("t5_data_out", data_out, 16'h1234);
        chk("t5_sof_count", n_sof, 1);

        // 6: reset mid-window at win_count 30 (strobe high during reset)
        for (int s = 0; s < 29; s++) send(1'b0, 1);
        idle(1);
        chk("t6_count_30", win_count, 30);
        @(negedge clk); reset = 1'b0; strobe = 1'b1; data_in = 16'h0001;
        @(negedge clk); reset = 1'b1; strobe = 1'b0;
        #2;
        chk("t6_win_count", win_count, 0);
        chk("t6_win_total", win_total, 0);
        chk("t6_in_window", in_window, 0);
        clr_counts();
        for (int s = 0; s < 3; s++) send(1'b0, 1);
        send(1'b1, 1);
        for (int s = 0; s < 3; s++) send(1'b0, 1);
        idle(2);
        chk("t6_no_len_valid", n_lv, 0);
        chk("t6_sof_count", n_sof, 1);
        chk("t6_win_total_1", win_total, 1);

`ifdef DATA_TAG_DECODE_STICKY_EN
        // sticky hold, clear, and clear colliding with a new error
        expected_len = 16'd8;
        send(1'b1, 1);
        send(1'b0, 1);
        send(1'b1, 1);
        idle(4);
        chk("st_held", err_short, 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #2;
        chk("st_cleared", err_short, 0);
        send(1'b0, 1);
        @(negedge clk); strobe = 1'b1; data_in = 16'h0001; err_clr = 1'b1;
        @(negedge clk); strobe = 1'b0; err_clr = 1'b0;
        #2;
        chk("st_clr_vs_new", err_short, 1);
`endif

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
